// File: rtl/vm_change_dispenser.sv
// rtl/vm_change_dispenser.sv - greedy coin change dispenser with per-denomination inventory
// Optional feature macro VM_LOW_STOCK_EN adds registered per-denomination o_low_stock flags.
module vm_change_dispenser #(
  parameter int N_DENOM = 15,
  parameter int VALUE_W = 21,
  parameter int CNT_W = 16,
  parameter logic [N_DENOM*VALUE_W-1:0] DENOM_VALUES = {
    21'd50000, 21'd20000, 21'd10000, 21'd5000, 21'd2000, 21'd1000, 21'd500, 21'd200,
    21'd100, 21'd50, 21'd25, 21'd10, 21'd5, 21'd2, 21'd1},
  parameter int INIT_AMOUNT = 100,
`ifdef VM_LOW_STOCK_EN
  parameter int LOW_THRESH = 4,
`endif
  localparam int CODE_W = $clog2(N_DENOM+1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [VALUE_W-1:0] i_req_amount,
  output logic               o_coin_valid,
  input  logic               i_coin_ready,
  output logic [CODE_W-1:0]  o_coin_code,
  output logic               o_done,
  output logic               o_no_change,
  output logic [VALUE_W-1:0] o_shortfall,
  output logic               o_busy,
  input  logic               i_deposit_valid,
  input  logic [CODE_W-1:0]  i_deposit_code
`ifdef VM_LOW_STOCK_EN
  ,output logic [N_DENOM-1:0] o_low_stock
`endif
);

  typedef enum logic [1:0] {IDLE, SELECT, OFFER, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_AMOUNT);

  state_t              state;
  logic [VALUE_W-1:0]  remaining;
  logic [CNT_W-1:0]    count [N_DENOM];
  logic [CODE_W-1:0]   sel_k;
  logic [VALUE_W-1:0]  denom_val [N_DENOM];
  logic                pick_found;
  logic [CODE_W-1:0]   pick_k;
  logic [N_DENOM-1:0]  dep_hit;
  logic [N_DENOM-1:0]  disp_hit;
  logic [VALUE_W-1:0]  rem_after;

  always_comb begin
    for (int k = 0; k < N_DENOM; k++) begin
      denom_val[k] = DENOM_VALUES[(N_DENOM-1-k)*VALUE_W +: VALUE_W];
    end
  end

  // Scan from the smallest coin upward so the largest fitting denomination wins.
  always_comb begin
    pick_found = 1'b0;
    pick_k     = '0;
    for (int k = N_DENOM-1; k >= 0; k--) begin
      if (count[k] != '0 && denom_val[k] <= remaining) begin
        pick_found = 1'b1;
        pick_k     = CODE_W'(k);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_DENOM; k++) begin
      dep_hit[k]  = i_deposit_valid && (i_deposit_code == CODE_W'(k+1));
      disp_hit[k] = (state == OFFER) && i_coin_ready && (sel_k == CODE_W'(k));
    end
  end

  assign rem_after   = remaining - denom_val[sel_k];
  assign o_req_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_DENOM; k++) begin
        count[k] <= CNT_INIT;
      end
    end else begin
      // A deposit and a dispense on the same denomination cancel out.
      for (int k = 0; k < N_DENOM; k++) begin
        if (dep_hit[k] && !disp_hit[k] && count[k] != CNT_MAX) begin
          count[k] <= count[k] + CNT_ONE;
        end else if (disp_hit[k] && !dep_hit[k]) begin
          count[k] <= count[k] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      remaining    <= '0;
      sel_k        <= '0;
      o_coin_valid <= 1'b0;
      o_coin_code  <= '0;
      o_done       <= 1'b0;
      o_no_change  <= 1'b0;
      o_shortfall  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            remaining <= i_req_amount;
            if (i_req_amount == '0) begin
              state       <= DONE;
              o_done      <= 1'b1;
              o_no_change <= 1'b0;
              o_shortfall <= '0;
            end else begin
              state <= SELECT;
            end
          end
        end
        SELECT: begin
          if (pick_found) begin
            sel_k        <= pick_k;
            o_coin_code  <= pick_k + CODE_W'(1);
            o_coin_valid <= 1'b1;
            state        <= OFFER;
          end else begin
            state       <= DONE;
            o_done      <= 1'b1;
            o_no_change <= (remaining != '0);
            o_shortfall <= remaining;
          end
        end
        OFFER: begin
          if (i_coin_ready) begin
            o_coin_valid <= 1'b0;
            o_coin_code  <= '0;
            remaining    <= rem_after;
            if (rem_after == '0) begin
              state       <= DONE;
              o_done      <= 1'b1;
              o_no_change <= 1'b0;
              o_shortfall <= '0;
            end else begin
              state <= SELECT;
            end
          end
        end
        DONE: begin
          o_done      <= 1'b0;
          o_no_change <= 1'b0;
          o_shortfall <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VM_LOW_STOCK_EN
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < N_DENOM; k++) begin
      if (i_rst) begin
        o_low_stock[k] <= (INIT_AMOUNT < LOW_THRESH);
      end else begin
        o_low_stock[k] <= (count[k] < CNT_W'(LOW_THRESH));
      end
    end
  end
`endif

endmodule

// File: tb/tb_vm_change_dispenser.sv
// tb/tb_vm_change_dispenser.sv - directed vector bench for vm_change_dispenser
// Three instances share stimulus: defaults, CNT_W=4/INIT=15, and INIT=0.
module tb_vm_change_dispenser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, coin_ready, dep_valid;
  logic [20:0] req_amount;
  logic [3:0]  dep_code;
  logic        req_ready [3];
  logic        coin_valid [3];
  logic        done [3];
  logic        no_change [3];
  logic        busy [3];
  logic [3:0]  coin_code [3];
  logic [20:0] shortfall [3];
`ifdef VM_LOW_STOCK_EN
  logic [14:0] low_stock [3];
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [20:0] amount;
    logic [4:0]  ncoins;
    logic [63:0] codes;
    logic [20:0] shortfall;
    logic        no_change;
    logic [3:0]  chk_k;
    logic [15:0] chk_cnt;
  } vec_t;

  vm_change_dispenser u_def (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready[0]),
    .i_req_amount(req_amount), .o_coin_valid(coin_valid[0]), .i_coin_ready(coin_ready),
    .o_coin_code(coin_code[0]), .o_done(done[0]), .o_no_change(no_change[0]),
    .o_shortfall(shortfall[0]), .o_busy(busy[0]), .i_deposit_valid(dep_valid),
`ifdef VM_LOW_STOCK_EN
    .o_low_stock(low_stock[0]),
`endif
    .i_deposit_code(dep_code)
  );

  vm_change_dispenser #(.CNT_W(4), .INIT_AMOUNT(15)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready[1]),
    .i_req_amount(req_amount), .o_coin_valid(coin_valid[1]), .i_coin_ready(coin_ready),
    .o_coin_code(coin_code[1]), .o_done(done[1]), .o_no_change(no_change[1]),
    .o_shortfall(shortfall[1]), .o_busy(busy[1]), .i_deposit_valid(dep_valid),
`ifdef VM_LOW_STOCK_EN
    .o_low_stock(low_stock[1]),
`endif
    .i_deposit_code(dep_code)
  );

  vm_change_dispenser #(.INIT_AMOUNT(0)) u_zero (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready[2]),
    .i_req_amount(req_amount), .o_coin_valid(coin_valid[2]), .i_coin_ready(coin_ready),
    .o_coin_code(coin_code[2]), .o_done(done[2]), .o_no_change(no_change[2]),
    .o_shortfall(shortfall[2]), .o_busy(busy[2]), .i_deposit_valid(dep_valid),
`ifdef VM_LOW_STOCK_EN
    .o_low_stock(low_stock[2]),
`endif
    .i_deposit_code(dep_code)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int amt, input int nco, input logic [63:0] cds,
                              input int sf, input bit nc, input int k, input int cnt);
    vec_t r;
    r.amount    = 21'(amt);
    r.ncoins    = 5'(nco);
    r.codes     = cds;
    r.shortfall = 21'(sf);
    r.no_change = nc;
    r.chk_k     = 4'(k);
    r.chk_cnt   = 16'(cnt);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; req_amount = '0; coin_ready = 1'b1;
    dep_valid = 1'b0; dep_code = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_coin(input int idx, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (coin_valid[idx]) ok = 1'b1;
      else @(negedge clk);
    end
    check("coin_offer_seen", 64'(ok), 64'(1));
  endtask

  // Issue one request and log every coin offered while i_coin_ready is high.
  task automatic do_req(input int idx, input logic [20:0] amt, output int n,
                        output logic [63:0] codes, output logic [20:0] sf,
                        output logic nc, output bit got);
    n = 0; codes = '0; sf = '0; nc = 1'b0; got = 1'b0;
    req_amount = amt; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (coin_valid[idx] && coin_ready) begin
        if (n < 16) codes[n*4 +: 4] = coin_code[idx];
        n++;
      end
      if (done[idx]) begin
        got = 1'b1; sf = shortfall[idx]; nc = no_change[idx];
      end
      if (!got) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [6];
    vec_t        v;
    int          n;
    logic [63:0] codes;
    logic [20:0] sf;
    logic        nc;
    bit          got, ok, seen_done;

    vecs[0] = mk(830,   5,  64'h00000000000DB987, 0, 1'b0, 6,  99);
    vecs[1] = mk(0,     0,  64'h0,                0, 1'b0, 0,  100);
    vecs[2] = mk(1,     1,  64'hF,                0, 1'b0, 14, 99);
    vecs[3] = mk(3,     2,  64'hFE,               0, 1'b0, 13, 99);
    vecs[4] = mk(40000, 2,  64'h22,               0, 1'b0, 1,  98);
    vecs[5] = mk(88888, 14, 64'h00FECBA987654321, 0, 1'b0, 12, 100);

    // Reset state
    rst = 1'b1; req_valid = 1'b0; req_amount = '0; coin_ready = 1'b1;
    dep_valid = 1'b0; dep_code = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready[0]), 64'(1));
    check("rst_coin_valid", 64'(coin_valid[0]), 64'(0));
    check("rst_coin_code", 64'(coin_code[0]), 64'(0));
    check("rst_done", 64'(done[0]), 64'(0));
    check("rst_busy", 64'(busy[0]), 64'(0));
    check("rst_shortfall", 64'(shortfall[0]), 64'(0));
    check("rst_cnt0", 64'(u_def.count[0]), 64'(100));
    check("rst_sat_cnt2", 64'(u_sat.count[2]), 64'(15));
`ifdef VM_LOW_STOCK_EN
    check("rst_low_def", 64'(low_stock[0]), 64'(0));
    check("rst_low_zero", 64'(low_stock[2]), 64'h7FFF);
`endif
    rst = 1'b0;

    // Table-driven requests on the default instance
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      do_reset();
      do_req(0, v.amount, n, codes, sf, nc, got);
      check($sformatf("v%0d_done", i), 64'(got), 64'(1));
      check($sformatf("v%0d_ncoins", i), 64'(n), 64'(v.ncoins));
      for (int j = 0; j < int'(v.ncoins); j++)
        check($sformatf("v%0d_code%0d", i, j), 64'(codes[j*4 +: 4]), 64'(v.codes[j*4 +: 4]));
      check($sformatf("v%0d_shortfall", i), 64'(sf), 64'(v.shortfall));
      check($sformatf("v%0d_no_change", i), 64'(nc), 64'(v.no_change));
      check($sformatf("v%0d_cnt", i), 64'(u_def.count[v.chk_k]), 64'(v.chk_cnt));
    end

    // Empty inventory: one deposited 10 pays part of 15, leaving 5 short
    do_reset();
    dep_valid = 1'b1; dep_code = 4'd12; @(negedge clk);
    dep_code = 4'd0; @(negedge clk);
    dep_valid = 1'b0;
    check("zero_dep_cnt11", 64'(u_zero.count[11]), 64'(1));
    do_req(2, 21'd15, n, codes, sf, nc, got);
    check("zero_done", 64'(got), 64'(1));
    check("zero_ncoins", 64'(n), 64'(1));
    check("zero_code", 64'(codes[3:0]), 64'(12));
    check("zero_shortfall", 64'(sf), 64'(5));
    check("zero_no_change", 64'(nc), 64'(1));
    check("zero_cnt11", 64'(u_zero.count[11]), 64'(0));
    @(negedge clk);
    check("zero_done_pulse", 64'(done[2]), 64'(0));

    // Stalled ejector; a second request during OFFER must be ignored
    do_reset();
    coin_ready = 1'b0;
    req_amount = 21'd100; req_valid = 1'b1; @(negedge clk);
    req_valid = 1'b0;
    wait_coin(0, ok);
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 64'(coin_valid[0]), 64'(1));
      check("stall_code", 64'(coin_code[0]), 64'(9));
      check("stall_cnt8", 64'(u_def.count[8]), 64'(100));
      req_valid = (c == 2); req_amount = 21'd7;
      @(negedge clk);
    end
    req_valid = 1'b0;
    coin_ready = 1'b1;
    @(negedge clk);
    check("stall_taken", 64'(coin_valid[0]), 64'(0));
    check("stall_cnt8_after", 64'(u_def.count[8]), 64'(99));
    check("stall_done", 64'(done[0]), 64'(1));
    check("stall_no_change", 64'(no_change[0]), 64'(0));
    @(negedge clk);
    check("stall_done_pulse", 64'(done[0]), 64'(0));
    check("stall_ready", 64'(req_ready[0]), 64'(1));
    repeat (3) @(negedge clk);
    check("stall_ignored_busy", 64'(busy[0]), 64'(0));
    check("stall_ignored_cnt", 64'(u_def.count[14]), 64'(100));

    // Saturation and simultaneous deposit/dispense
    do_reset();
    dep_valid = 1'b1; dep_code = 4'd3; @(negedge clk);
    dep_valid = 1'b0;
    check("sat_dep", 64'(u_sat.count[2]), 64'(15));
    check("def_dep", 64'(u_def.count[2]), 64'(101));
    coin_ready = 1'b0;
    req_amount = 21'd10000; req_valid = 1'b1; @(negedge clk);
    req_valid = 1'b0;
    wait_coin(1, ok);
    check("sat_code", 64'(coin_code[1]), 64'(3));
    coin_ready = 1'b1; dep_valid = 1'b1; dep_code = 4'd3; @(negedge clk);
    dep_valid = 1'b0;
    check("sat_both", 64'(u_sat.count[2]), 64'(15));
    check("def_both", 64'(u_def.count[2]), 64'(101));
    check("sat_taken", 64'(coin_valid[1]), 64'(0));

    // Reset while a coin is on offer
    do_reset();
    coin_ready = 1'b0;
    req_amount = 21'd830; req_valid = 1'b1; @(negedge clk);
    req_valid = 1'b0;
    wait_coin(0, ok);
    rst = 1'b1; @(negedge clk);
    check("abort_valid", 64'(coin_valid[0]), 64'(0));
    check("abort_ready", 64'(req_ready[0]), 64'(1));
    check("abort_done", 64'(done[0]), 64'(0));
    check("abort_cnt6", 64'(u_def.count[6]), 64'(100));
    rst = 1'b0; coin_ready = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done[0] || coin_valid[0]) seen_done = 1'b1;
    end
    check("abort_quiet", 64'(seen_done), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
